control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Clock  input  1  system clock; all state changes on rising edge.
REQ-002 Clear  input  1  reset, asynchronous, active-low.
REQ-003 opcode  input  5  IR[31:27] from datapath; valid from T3 onward.
REQ-004 Stop  input  1  pause request; sampled only at instruction boundary.
REQ-005 PCout, ZLowout, MDRout, MARin, PCin, MDRin, IRin, Yin, IncPC, Read, ZLowIn, Cout, RAMin  output  1 each  datapath strobes.
REQ-006 GRA, GRB, GRC, BAout, Rin, Rout  output  1 each  register-select strobes.
REQ-007 ZHighout, ZHighIn, HIin, LOin, HIout, LOout, CONin, InPortOut, OutPortIn  output  1 each  tied 0 in this revision.
REQ-008 Run  output  1  high while executing; low in IDLE_S and HALT_S.

Function
REQ-009 FSM states SHALL be IDLE_S, T0-T7, HALT_S; one state per clock.
REQ-010 Outputs SHALL be Moore, decoded combinationally from the registered state and opcode; every strobe not listed for a state is 0.
REQ-011 Opcodes: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110, addi 01100, jr 10100, nop 11010, halt 11011; any other value SHALL execute as nop.
REQ-012 IDLE_S -> T0 when Stop=0; stays IDLE_S while Stop=1.
REQ-013 Fetch, all instructions: T0 PCout MARin IncPC ZLowIn; T1 ZLowout PCin Read MDRin; T2 MDRout IRin; T2 -> T3 unconditionally.
REQ-014 ldi: T3 GRB BAout Yin; T4 Cout ZLowIn; T5 ZLowout GRA Rin; end at T5.
REQ-015 ld: T3-T4 as ldi; T5 ZLowout MARin; T6 Read MDRin; T7 MDRout GRA Rin; end at T7.
REQ-016 st: T3-T4 as ldi; T5 ZLowout MARin; T6 GRA Rout MDRin (Read=0); T7 RAMin; end at T7.
REQ-017 add/sub/and/or: T3 GRB Rout Yin; T4 GRC Rout ZLowIn; T5 ZLowout GRA Rin; end at T5.
REQ-018 addi: T3 GRB Rout Yin; T4 Cout ZLowIn; T5 ZLowout GRA Rin; end at T5.
REQ-019 jr: T3 GRA Rout PCin; end at T3.
REQ-020 nop: T3 all strobes 0; end at T3.
REQ-021 halt: T3 -> HALT_S; HALT_S holds with all strobes 0 and Run=0 until Clear.
REQ-022 At end state, next state SHALL be T0 if Stop=0, else IDLE_S; Stop mid-instruction SHALL NOT truncate it.
REQ-023 Latency (T0 to last state inclusive): jr/nop 4, ldi/ALU/addi 6, ld/st 8 cycles.
REQ-024 opcode changes during T3-T7 SHALL be followed combinationally; controller does not latch opcode.
REQ-025 Rin and Rout SHALL never be 1 in the same state; BAout SHALL imply Rout=0.

Reset
REQ-026 Clear=0 SHALL force IDLE_S immediately, independent of Clock, with all outputs 0.
REQ-027 Clear asserted mid-instruction SHALL abort it; no strobe glitch after assertion.
REQ-028 First rising edge after Clear deasserts with Stop=0 SHALL enter T0.

Verification
REQ-029 Reset then Stop=0, opcode=00001 -> states T0..T5; T5 shows ZLowout=GRA=Rin=1; next cycle T0; Run=1 throughout.
REQ-030 opcode=00000 -> T6 Read=MDRin=1, T7 MDRout=GRA=Rin=1; 8 cycles then T0.
REQ-031 opcode=00010 -> T6 GRA=Rout=MDRin=1, Read=0; T7 RAMin=1 only.
REQ-032 opcode=11011 -> after T3 enter HALT_S, Run=0 for 20 cycles; Clear pulse -> IDLE_S then T0.
REQ-033 Stop=1 asserted at ld T4 -> ld completes through T7, then IDLE_S; Stop=0 -> T0 next edge.
REQ-034 Clear=0 asynchronously at ld T6 -> all outputs 0 before next edge; opcode=11111 -> nop timing (4 cycles).

Source files
------------

// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit
//
// Hardwired Moore controller for a simple load/store datapath. Each
// instruction is a fetch (T0-T2) followed by an opcode-dependent execute
// sequence (T3-T7). The controller can also sit in IDLE_S between
// instructions or stop permanently in HALT_S.
//
// Strobes are decoded combinationally from the registered state and the live
// opcode. The opcode is not latched, so an opcode change during T3-T7 is
// reflected in the strobes immediately.
//
// Ports
//   Clock      in   system clock, rising edge
//   Clear      in   asynchronous active-low reset
//   opcode[4:0] in  IR[31:27] from the datapath, valid from T3 onward
//   Stop       in   pause request, sampled only at instruction boundaries
//   PCout .. RAMin        out  datapath strobes
//   GRA .. Rout           out  register-select strobes
//   ZHighout .. OutPortIn out  unused strobes, tied low
//   Run        out  high while an instruction is executing
// ---------------------------------------------------------------------------
module control_unit (
    input  logic       Clock,
    input  logic       Clear,
    input  logic [4:0] opcode,
    input  logic       Stop,
    output logic       PCout,
    output logic       ZLowout,
    output logic       MDRout,
    output logic       MARin,
    output logic       PCin,
    output logic       MDRin,
    output logic       IRin,
    output logic       Yin,
    output logic       IncPC,
    output logic       Read,
    output logic       ZLowIn,
    output logic       Cout,
    output logic       RAMin,
    output logic       GRA,
    output logic       GRB,
    output logic       GRC,
    output logic       BAout,
    output logic       Rin,
    output logic       Rout,
    output logic       ZHighout,
    output logic       ZHighIn,
    output logic       HIin,
    output logic       LOin,
    output logic       HIout,
    output logic       LOout,
    output logic       CONin,
    output logic       InPortOut,
    output logic       OutPortIn,
    output logic       Run
);

    typedef enum logic [3:0] {
        IDLE_S,
        T0,
        T1,
        T2,
        T3,
        T4,
        T5,
        T6,
        T7,
        HALT_S
    } state_t;

    // Instruction classes that share an execute sequence.
    typedef enum logic [2:0] {
        OP_LD,
        OP_LDI,
        OP_ST,
        OP_ALU,
        OP_ADDI,
        OP_JR,
        OP_NOP,
        OP_HALT
    } op_class_t;

    state_t    state;
    state_t    state_next;
    state_t    end_next;
    op_class_t op_class;

    // Unused strobes in this revision.
    assign ZHighout  = 1'b0;
    assign ZHighIn   = 1'b0;
    assign HIin      = 1'b0;
    assign LOin      = 1'b0;
    assign HIout     = 1'b0;
    assign LOout     = 1'b0;
    assign CONin     = 1'b0;
    assign InPortOut = 1'b0;
    assign OutPortIn = 1'b0;

    // Opcode decode; any unlisted encoding behaves as nop.
    always_comb begin
        op_class = OP_NOP;
        case (opcode)
            5'b00000: op_class = OP_LD;
            5'b00001: op_class = OP_LDI;
            5'b00010: op_class = OP_ST;
            5'b00011,
            5'b00100,
            5'b00101,
            5'b00110: op_class = OP_ALU;
            5'b01100: op_class = OP_ADDI;
            5'b10100: op_class = OP_JR;
            5'b11011: op_class = OP_HALT;
            default:  op_class = OP_NOP;
        endcase
    end

    // State register. Clear forces IDLE_S without waiting for a clock edge,
    // which also drives every Moore output low at once.
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state <= IDLE_S;
        end else begin
            state <= state_next;
        end
    end

    // Next state. Stop is only consulted at IDLE_S and at the last state of
    // an instruction, so a pause request never truncates execution.
    always_comb begin
        end_next   = Stop ? IDLE_S : T0;
        state_next = state;
        case (state)
            IDLE_S: state_next = Stop ? IDLE_S : T0;
            T0:     state_next = T1;
            T1:     state_next = T2;
            T2:     state_next = T3;
            T3: begin
                case (op_class)
                    OP_JR,
                    OP_NOP:  state_next = end_next;
                    OP_HALT: state_next = HALT_S;
                    default: state_next = T4;
                endcase
            end
            T4:     state_next = T5;
            T5: begin
                if (op_class == OP_LD || op_class == OP_ST) begin
                    state_next = T6;
                end else begin
                    state_next = end_next;
                end
            end
            T6:     state_next = T7;
            T7:     state_next = end_next;
            HALT_S: state_next = HALT_S;
            default: state_next = IDLE_S;
        endcase
    end

    // Moore strobe decode. BAout is used instead of Rout for the base
    // register of memory instructions so that R0 reads as zero; Rin and Rout
    // are never asserted in the same state.
    always_comb begin
        PCout   = 1'b0;
        ZLowout = 1'b0;
        MDRout  = 1'b0;
        MARin   = 1'b0;
        PCin    = 1'b0;
        MDRin   = 1'b0;
        IRin    = 1'b0;
        Yin     = 1'b0;
        IncPC   = 1'b0;
        Read    = 1'b0;
        ZLowIn  = 1'b0;
        Cout    = 1'b0;
        RAMin   = 1'b0;
        GRA     = 1'b0;
        GRB     = 1'b0;
        GRC     = 1'b0;
        BAout   = 1'b0;
        Rin     = 1'b0;
        Rout    = 1'b0;
        Run     = (state != IDLE_S) && (state != HALT_S);

        case (state)
            T0: begin
                PCout  = 1'b1;
                MARin  = 1'b1;
                IncPC  = 1'b1;
                ZLowIn = 1'b1;
            end
            T1: begin
                ZLowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            T3: begin
                case (op_class)
                    OP_LD, OP_LDI, OP_ST: begin
                        GRB   = 1'b1;
                        BAout = 1'b1;
                        Yin   = 1'b1;
                    end
                    OP_ALU, OP_ADDI: begin
                        GRB  = 1'b1;
                        Rout = 1'b1;
                        Yin  = 1'b1;
                    end
                    OP_JR: begin
                        GRA  = 1'b1;
                        Rout = 1'b1;
                        PCin = 1'b1;
                    end
                    default: ;
                endcase
            end
            T4: begin
                case (op_class)
                    OP_LD, OP_LDI, OP_ST, OP_ADDI: begin
                        Cout   = 1'b1;
                        ZLowIn = 1'b1;
                    end
                    OP_ALU: begin
                        GRC    = 1'b1;
                        Rout   = 1'b1;
                        ZLowIn = 1'b1;
                    end
                    default: ;
                endcase
            end
            T5: begin
                case (op_class)
                    OP_LDI, OP_ALU, OP_ADDI: begin
                        ZLowout = 1'b1;
                        GRA     = 1'b1;
                        Rin     = 1'b1;
                    end
                    OP_LD, OP_ST: begin
                        ZLowout = 1'b1;
                        MARin   = 1'b1;
                    end
                    default: ;
                endcase
            end
            T6: begin
                case (op_class)
                    OP_LD: begin
                        Read  = 1'b1;
                        MDRin = 1'b1;
                    end
                    // Store data comes from the register file, not memory.
                    OP_ST: begin
                        GRA   = 1'b1;
                        Rout  = 1'b1;
                        MDRin = 1'b1;
                    end
                    default: ;
                endcase
            end
            T7: begin
                case (op_class)
                    OP_LD: begin
                        MDRout = 1'b1;
                        GRA    = 1'b1;
                        Rin    = 1'b1;
                    end
                    OP_ST: begin
                        RAMin = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// ---------------------------------------------------------------------------
// tb_control_unit
//
// Directed testbench for control_unit. Each scenario task drives the opcode,
// Stop and Clear inputs and compares the full strobe vector against
// hand-written expected vectors, sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_control_unit;

    logic       Clock;
    logic       Clear;
    logic [4:0] opcode;
    logic       Stop;
    logic PCout, ZLowout, MDRout, MARin, PCin, MDRin, IRin, Yin, IncPC, Read;
    logic ZLowIn, Cout, RAMin, GRA, GRB, GRC, BAout, Rin, Rout;
    logic ZHighout, ZHighIn, HIin, LOin, HIout, LOout, CONin, InPortOut, OutPortIn;
    logic Run;

    int checks = 0;
    int errors = 0;

    control_unit dut (
        .Clock     (Clock),
        .Clear     (Clear),
        .opcode    (opcode),
        .Stop      (Stop),
        .PCout     (PCout),
        .ZLowout   (ZLowout),
        .MDRout    (MDRout),
        .MARin     (MARin),
        .PCin      (PCin),
        .MDRin     (MDRin),
        .IRin      (IRin),
        .Yin       (Yin),
        .IncPC     (IncPC),
        .Read      (Read),
        .ZLowIn    (ZLowIn),
        .Cout      (Cout),
        .RAMin     (RAMin),
        .GRA       (GRA),
        .GRB       (GRB),
        .GRC       (GRC),
        .BAout     (BAout),
        .Rin       (Rin),
        .Rout      (Rout),
        .ZHighout  (ZHighout),
        .ZHighIn   (ZHighIn),
        .HIin      (HIin),
        .LOin      (LOin),
        .HIout     (HIout),
        .LOout     (LOout),
        .CONin     (CONin),
        .InPortOut (InPortOut),
        .OutPortIn (OutPortIn),
        .Run       (Run)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Strobe bit masks, ordered as in obs().
    localparam logic [19:0] M_PCOUT   = 20'h80000;
    localparam logic [19:0] M_ZLOWOUT = 20'h40000;
    localparam logic [19:0] M_MDROUT  = 20'h20000;
    localparam logic [19:0] M_MARIN   = 20'h10000;
    localparam logic [19:0] M_PCIN    = 20'h08000;
    localparam logic [19:0] M_MDRIN   = 20'h04000;
    localparam logic [19:0] M_IRIN    = 20'h02000;
    localparam logic [19:0] M_YIN     = 20'h01000;
    localparam logic [19:0] M_INCPC   = 20'h00800;
    localparam logic [19:0] M_READ    = 20'h00400;
    localparam logic [19:0] M_ZLOWIN  = 20'h00200;
    localparam logic [19:0] M_COUT    = 20'h00100;
    localparam logic [19:0] M_RAMIN   = 20'h00080;
    localparam logic [19:0] M_GRA     = 20'h00040;
    localparam logic [19:0] M_GRB     = 20'h00020;
    localparam logic [19:0] M_GRC     = 20'h00010;
    localparam logic [19:0] M_BAOUT   = 20'h00008;
    localparam logic [19:0] M_RIN     = 20'h00004;
    localparam logic [19:0] M_ROUT    = 20'h00002;
    localparam logic [19:0] M_RUN     = 20'h00001;

    localparam logic [19:0] E_T0 = M_PCOUT | M_MARIN | M_INCPC | M_ZLOWIN | M_RUN;
    localparam logic [19:0] E_T1 = M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN | M_RUN;
    localparam logic [19:0] E_T2 = M_MDROUT | M_IRIN | M_RUN;
    localparam logic [19:0] E_MEM_T3 = M_GRB | M_BAOUT | M_YIN | M_RUN;
    localparam logic [19:0] E_IMM_T4 = M_COUT | M_ZLOWIN | M_RUN;
    localparam logic [19:0] E_WB_T5  = M_ZLOWOUT | M_GRA | M_RIN | M_RUN;
    localparam logic [19:0] E_MEM_T5 = M_ZLOWOUT | M_MARIN | M_RUN;
    localparam logic [19:0] E_LD_T6  = M_READ | M_MDRIN | M_RUN;
    localparam logic [19:0] E_LD_T7  = M_MDROUT | M_GRA | M_RIN | M_RUN;
    localparam logic [19:0] E_ST_T6  = M_GRA | M_ROUT | M_MDRIN | M_RUN;
    localparam logic [19:0] E_ST_T7  = M_RAMIN | M_RUN;
    localparam logic [19:0] E_ALU_T3 = M_GRB | M_ROUT | M_YIN | M_RUN;
    localparam logic [19:0] E_ALU_T4 = M_GRC | M_ROUT | M_ZLOWIN | M_RUN;
    localparam logic [19:0] E_JR_T3  = M_GRA | M_ROUT | M_PCIN | M_RUN;
    localparam logic [19:0] E_NOP_T3 = M_RUN;
    localparam logic [19:0] E_IDLE   = 20'h00000;

    function automatic logic [19:0] obs();
        return {PCout, ZLowout, MDRout, MARin, PCin, MDRin, IRin, Yin, IncPC,
                Read, ZLowIn, Cout, RAMin, GRA, GRB, GRC, BAout, Rin, Rout, Run};
    endfunction

    function automatic logic [8:0] tied();
        return {ZHighout, ZHighIn, HIin, LOin, HIout, LOout, CONin, InPortOut,
                OutPortIn};
    endfunction

    // Bring the controller to IDLE_S with Stop held high (stimulus only).
    task automatic go_idle();
        @(negedge Clock);
        Stop  = 1'b1;
        Clear = 1'b0;
        @(negedge Clock);
        Clear = 1'b1;
        @(negedge Clock);
    endtask

    task automatic test_reset();
        Clear  = 1'b0;
        Stop   = 1'b1;
        opcode = 5'b00000;
        #1;
        checks++;
        if (obs() !== E_IDLE) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected %h", obs(), E_IDLE);
        end
        checks++;
        if (tied() !== 9'h000) begin
            errors++;
            $display("FAIL reset_tied: got %h expected %h", tied(), 9'h000);
        end
        @(negedge Clock);
        Clear = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge Clock);
            @(negedge Clock);
            checks++;
            if (obs() !== E_IDLE) begin
                errors++;
                $display("FAIL idle_hold[%0d]: got %h expected %h", i, obs(), E_IDLE);
            end
        end
        Stop = 1'b0;
        @(posedge Clock);
        @(negedge Clock);
        checks++;
        if (obs() !== E_T0) begin
            errors++;
            $display("FAIL idle_to_t0: got %h expected %h", obs(), E_T0);
        end
    endtask

    task automatic test_ldi();
        logic [19:0] exp_v [7];
        exp_v = '{E_T0, E_T1, E_T2, E_MEM_T3, E_IMM_T4, E_WB_T5, E_T0};
        go_idle();
        opcode = 5'b00001;
        Stop   = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(posedge Clock);
            @(negedge Clock);
            checks++;
            if (obs() !== exp_v[i]) begin
                errors++;
                $display("FAIL ldi_step[%0d]: got %h expected %h", i, obs(), exp_v[i]);
            end
        end
    endtask

    task automatic test_ld();
        logic [19:0] exp_v [9];
        exp_v = '{E_T0, E_T1, E_T2, E_MEM_T3, E_IMM_T4, E_MEM_T5, E_LD_T6, E_LD_T7, E_T0};
        go_idle();
        opcode = 5'b00000;
        Stop   = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(posedge Clock);
            @(negedge Clock);
            checks++;
            if (obs() !== exp_v[i]) begin
                errors++;
                $display("FAIL ld_step[%0d]: got %h expected %h", i, obs(), exp_v[i]);
            end
        end
    endtask

    task automatic test_st();
        logic [19:0] exp_v [9];
        exp_v = '{E_T0, E_T1, E_T2, E_MEM_T3, E_IMM_T4, E_MEM_T5, E_ST_T6, E_ST_T7, E_T0};
        go_idle();
        opcode = 5'b00010;
        Stop   = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(posedge Clock);
            @(negedge Clock);
            checks++;
            if (obs() !== exp_v[i]) begin
                errors++;
                $display("FAIL st_step[%0d]: got %h expected %h", i, obs(), exp_v[i]);
            end
        end
    endtask

    // add, sub, and, or, then addi, all back to back from one IDLE exit.
    task automatic test_alu();
        logic [4:0]  ops [5];
        logic [19:0] exp_v [6];
        ops = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b01100};
        go_idle();
        Stop = 1'b0;
        for (int k = 0; k < 5; k++) begin
            opcode = ops[k];
            if (k == 4) exp_v = '{E_T0, E_T1, E_T2, E_ALU_T3, E_IMM_T4, E_WB_T5};
            else        exp_v = '{E_T0, E_T1, E_T2, E_ALU_T3, E_ALU_T4, E_WB_T5};
            for (int i = 0; i < 6; i++) begin
                @(posedge Clock);
                @(negedge Clock);
                checks++;
                if (obs() !== exp_v[i]) begin
                    errors++;
                    $display("FAIL alu_op%0d_step[%0d]: got %h expected %h", k, i, obs(), exp_v[i]);
                end
            end
        end
        @(posedge Clock);
        @(negedge Clock);
        checks++;
        if (obs() !== E_T0) begin
            errors++;
            $display("FAIL alu_back_to_back: got %h expected %h", obs(), E_T0);
        end
    endtask

    // Opcode is followed combinationally in T3: switch add to jr mid-state.
    task automatic test_jr_and_follow();
        logic [19:0] exp_v [5];
        exp_v = '{E_T0, E_T1, E_T2, E_JR_T3, E_T0};
        go_idle();
        opcode = 5'b10100;
        Stop   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge Clock);
            @(negedge Clock);
            checks++;
            if (obs() !== exp_v[i]) begin
                errors++;
                $display("FAIL jr_step[%0d]: got %h expected %h", i, obs(), exp_v[i]);
            end
        end
        opcode = 5'b00011;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        checks++;
        if (obs() !== E_ALU_T3) begin
            errors++;
            $display("FAIL follow_add_t3: got %h expected %h", obs(), E_ALU_T3);
        end
        opcode = 5'b10100;
        #1;
        checks++;
        if (obs() !== E_JR_T3) begin
            errors++;
            $display("FAIL follow_jr_t3: got %h expected %h", obs(), E_JR_T3);
        end
        @(posedge Clock);
        @(negedge Clock);
        checks++;
        if (obs() !== E_T0) begin
            errors++;
            $display("FAIL follow_jr_end: got %h expected %h", obs(), E_T0);
        end
    endtask

    task automatic test_halt();
        logic [19:0] exp_v [4];
        exp_v = '{E_T0, E_T1, E_T2, E_NOP_T3};
        go_idle();
        opcode = 5'b11011;
        Stop   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge Clock);
            @(negedge Clock);
            checks++;
            if (obs() !== exp_v[i]) begin
                errors++;
                $display("FAIL halt_step[%0d]: got %h expected %h", i, obs(), exp_v[i]);
            end
        end
        for (int i = 0; i < 20; i++) begin
            @(posedge Clock);
            @(negedge Clock);
            checks++;
            if (obs() !== E_IDLE) begin
                errors++;
                $display("FAIL halt_hold[%0d]: got %h expected %h", i, obs(), E_IDLE);
            end
        end
        Clear = 1'b0;
        #1;
        checks++;
        if (obs() !== E_IDLE) begin
            errors++;
            $display("FAIL halt_clear: got %h expected %h", obs(), E_IDLE);
        end
        @(negedge Clock);
        Clear  = 1'b1;
        opcode = 5'b11010;
        @(posedge Clock);
        @(negedge Clock);
        checks++;
        if (obs() !== E_T0) begin
            errors++;
            $display("FAIL halt_restart: got %h expected %h", obs(), E_T0);
        end
    endtask

    // Stop raised during ld T4 must not truncate the instruction.
    task automatic test_stop_mid();
        logic [19:0] exp_v [8];
        exp_v = '{E_T0, E_T1, E_T2, E_MEM_T3, E_IMM_T4, E_MEM_T5, E_LD_T6, E_LD_T7};
        go_idle();
        opcode = 5'b00000;
        Stop   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge Clock);
            @(negedge Clock);
            checks++;
            if (obs() !== exp_v[i]) begin
                errors++;
                $display("FAIL stop_step[%0d]: got %h expected %h", i, obs(), exp_v[i]);
            end
            if (i == 4) Stop = 1'b1;
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge Clock);
            @(negedge Clock);
            checks++;
            if (obs() !== E_IDLE) begin
                errors++;
                $display("FAIL stop_idle[%0d]: got %h expected %h", i, obs(), E_IDLE);
            end
        end
        Stop = 1'b0;
        @(posedge Clock);
        @(negedge Clock);
        checks++;
        if (obs() !== E_T0) begin
            errors++;
            $display("FAIL stop_resume: got %h expected %h", obs(), E_T0);
        end
    endtask

    // Asynchronous abort at ld T6, then an undefined opcode runs as nop.
    task automatic test_async_clear();
        logic [19:0] exp_v [5];
        go_idle();
        opcode = 5'b00000;
        Stop   = 1'b0;
        repeat (7) @(posedge Clock);
        @(negedge Clock);
        checks++;
        if (obs() !== E_LD_T6) begin
            errors++;
            $display("FAIL abort_at_t6: got %h expected %h", obs(), E_LD_T6);
        end
        #2;
        Clear = 1'b0;
        #1;
        checks++;
        if (obs() !== E_IDLE) begin
            errors++;
            $display("FAIL abort_async: got %h expected %h", obs(), E_IDLE);
        end
        checks++;
        if (tied() !== 9'h000) begin
            errors++;
            $display("FAIL abort_tied: got %h expected %h", tied(), 9'h000);
        end
        @(negedge Clock);
        Clear  = 1'b1;
        opcode = 5'b11111;
        exp_v  = '{E_T0, E_T1, E_T2, E_NOP_T3, E_T0};
        for (int i = 0; i < 5; i++) begin
            @(posedge Clock);
            @(negedge Clock);
            checks++;
            if (obs() !== exp_v[i]) begin
                errors++;
                $display("FAIL undef_nop_step[%0d]: got %h expected %h", i, obs(), exp_v[i]);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, errors %0d", errors);
        $fatal(1);
    end

    initial begin
        Clear  = 1'b0;
        Stop   = 1'b1;
        opcode = 5'b00000;
        test_reset();
        test_ldi();
        test_ld();
        test_st();
        test_alu();
        test_jr_and_follow();
        test_halt();
        test_stop_mid();
        test_async_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
